// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX serializer among NUM_REQ byte sources.
// Optional post-frame idle gap enabled by defining UART_ARB_GAP_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned TIMEOUT_CLKS = 11 * CLKS_PER_BIT + 16,
  parameter int unsigned GAP_CLKS     = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic                 o_Err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [31:0]      CFG_BITS  = 32'(GAP_CLKS) ^ 32'(CLKS_PER_BIT);

`ifdef UART_ARB_GAP_EN
  localparam int unsigned      GAP_W    = $clog2(GAP_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;
`endif

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [CNT_W-1:0] cnt;
`ifdef UART_ARB_GAP_EN
  logic [GAP_W-1:0] gap_cnt;
`endif

  logic             any_req;
  logic [PTR_W-1:0] sel;
  logic [PTR_W:0]   idx;
  logic [NUM_REQ-1:0] sel_onehot;

  // Activity is tracked with Done alone; Active and the sizing parameters feed nothing.
  logic unused_ok;
  assign unused_ok = i_TX_Active ^ (^CFG_BITS);

  // Search from the pointer upward with wrap; the descending loop lets the
  // closest requester (smallest offset) be the last one written.
  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (idx >= NUM_REQ_X) idx = idx - NUM_REQ_X;
      if (i_Req_Valid[idx[PTR_W-1:0]]) begin
        any_req = 1'b1;
        sel     = idx[PTR_W-1:0];
      end
    end
  end

  assign sel_onehot = NUM_REQ'(1) << sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      cnt       <= '0;
`ifdef UART_ARB_GAP_EN
      gap_cnt   <= '0;
`endif
      o_Req_Ack <= '0;
      o_Grant   <= '0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
      o_Busy    <= 1'b0;
      o_Err     <= 1'b0;
    end else begin
      o_TX_DV   <= 1'b0;
      o_Req_Ack <= '0;
      o_Err     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= LOAD;
            gidx      <= sel;
            o_Grant   <= sel_onehot;
            o_Req_Ack <= sel_onehot;
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= i_Req_Byte[{sel, 3'b000} +: 8];
            o_Busy    <= 1'b1;
          end
        end
        LOAD: begin
          state <= WAIT_DONE;
          ptr   <= (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);
          cnt   <= CNT_W'(1);
        end
        WAIT_DONE: begin
          // Done takes priority over a timeout landing on the same edge.
          if (i_TX_Done) begin
            o_Grant <= '0;
`ifdef UART_ARB_GAP_EN
            state   <= GAP;
            gap_cnt <= '0;
`else
            state   <= IDLE;
            o_Busy  <= 1'b0;
`endif
          end else if (cnt == CNT_LAST) begin
            o_Err   <= 1'b1;
            o_Grant <= '0;
            state   <= IDLE;
            o_Busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_ARB_GAP_EN
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// frames compared against a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int CLKS_PER_BIT = 217;
  localparam int TIMEOUT_CLKS = 11 * CLKS_PER_BIT + 16;
  localparam int GAP_CLKS     = 16;
`ifdef UART_ARB_GAP_EN
  localparam int GAP_EXTRA = GAP_CLKS;
`else
  localparam int GAP_EXTRA = 0;
`endif
  // Cycles from the Done cycle to the next DV cycle when a request is pending.
  localparam int DV_AFTER_DONE = 2 + GAP_EXTRA;

  logic                 clk = 1'b0;
  logic                 i_Rst_L = 1'b0;
  logic [NUM_REQ-1:0]   i_Req_Valid = '0;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   o_Req_Ack;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active = 1'b0;
  logic                 i_TX_Done = 1'b0;
  logic                 o_Busy;
  logic                 o_Err;

  logic [7:0] m_byte [NUM_REQ];
  int         m_ptr = 0;
  int         next_lat = 1;
  int         checks = 0;
  int         failures = 0;
  logic [NUM_REQ-1:0] gg;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CLKS_PER_BIT),
    .TIMEOUT_CLKS(TIMEOUT_CLKS), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .i_Clock(clk), .i_Rst_L(i_Rst_L),
    .i_Req_Valid(i_Req_Valid), .i_Req_Byte(i_Req_Byte),
    .o_Req_Ack(o_Req_Ack), .o_Grant(o_Grant),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .i_TX_Active(i_TX_Active), .i_TX_Done(i_TX_Done),
    .o_Busy(o_Busy), .o_Err(o_Err)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_Req_Byte = '0;
    for (int r = 0; r < NUM_REQ; r++) i_Req_Byte[8*r +: 8] = m_byte[r];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference round robin: first valid requester at or after the pointer, modulo NUM_REQ.
  function automatic int pick(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_Rst_L = 1'b0;
    i_Req_Valid = '0;
    i_TX_Done = 1'b0;
    i_TX_Active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_Rst_L = 1'b1;
    m_ptr = 0;
    next_lat = 1;
  endtask

  // Wait until the arbiter is idle, then present a new request mask.
  task automatic kick(input logic [NUM_REQ-1:0] mask);
    int n = 0;
    while (o_Busy && n < GAP_CLKS + TIMEOUT_CLKS + 8) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_kick", o_Busy, 0);
    i_Req_Valid = mask;
    next_lat = 1;
  endtask

  // One frame: wait for DV, check the grant against the model, then finish the
  // frame with Done after done_delay cycles or let the watchdog fire.
  // mode 0: granted requester drops valid; 1: keeps it; 2: random churn.
  task automatic do_frame(input int mode, input bit tmo, input int done_delay,
                          input logic [NUM_REQ-1:0] add_mask,
                          output logic [NUM_REQ-1:0] got_grant);
    int g, n, r;
    logic [7:0] exp_byte;
    logic [NUM_REQ-1:0] onehot;
    bit bad;
    g = pick(i_Req_Valid, m_ptr);
    onehot = '0;
    exp_byte = '0;
    if (g >= 0) begin
      onehot[g] = 1'b1;
      exp_byte = m_byte[g];
    end
    n = 0;
    while (!o_TX_DV && n < next_lat + GAP_CLKS + 8) begin
      @(negedge clk);
      n++;
    end
    check("dv_latency", n, next_lat);
    check("ack", o_Req_Ack, onehot);
    check("grant", o_Grant, onehot);
    check("tx_byte", o_TX_Byte, exp_byte);
    check("busy_load", o_Busy, 1);
    check("err_load", o_Err, 0);
    got_grant = o_Grant;
    if (g >= 0) begin
      m_ptr = (g + 1) % NUM_REQ;
      if (mode == 0 || (mode == 2 && $urandom_range(0, 1) == 0)) i_Req_Valid[g] = 1'b0;
      else if (mode == 2) m_byte[g] = 8'($urandom);
    end
    i_TX_Active = 1'b1;
    @(negedge clk);
    check("dv_pulse", o_TX_DV, 0);
    check("ack_pulse", o_Req_Ack, 0);
    i_Req_Valid = i_Req_Valid | add_mask;
    if (tmo) begin
      n = 1;
      while (!o_Err && n < TIMEOUT_CLKS + 8) begin
        @(negedge clk);
        n++;
      end
      check("err_latency", n, TIMEOUT_CLKS);
      check("grant_after_err", o_Grant, 0);
      check("busy_after_err", o_Busy, 0);
      i_TX_Active = 1'b0;
      next_lat = 1;
    end else begin
      bad = 1'b0;
      for (int i = 1; i < done_delay; i++) begin
        if (o_Grant !== onehot || o_TX_Byte !== exp_byte || o_Busy !== 1'b1 || o_Err !== 1'b0) bad = 1'b1;
        if (mode == 2 && $urandom_range(0, 7) == 0) begin
          r = $urandom_range(0, NUM_REQ - 1);
          if (i_Req_Valid[r]) i_Req_Valid[r] = 1'b0;
          else begin
            m_byte[r] = 8'($urandom);
            i_Req_Valid[r] = 1'b1;
          end
        end
        @(negedge clk);
      end
      if (o_Grant !== onehot || o_TX_Byte !== exp_byte || o_Busy !== 1'b1 || o_Err !== 1'b0) bad = 1'b1;
      check("frame_hold", bad, 0);
      i_TX_Done = 1'b1;
      @(negedge clk);
      i_TX_Done = 1'b0;
      i_TX_Active = 1'b0;
      check("grant_clear", o_Grant, 0);
      check("busy_after_done", o_Busy, GAP_EXTRA > 0);
      check("err_after_done", o_Err, 0);
      next_lat = DV_AFTER_DONE - 1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    for (int r = 0; r < NUM_REQ; r++) m_byte[r] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {o_Req_Ack, o_Grant, o_TX_DV, o_TX_Byte, o_Busy, o_Err}, 0);
    i_Rst_L = 1'b1;

    // Done while idle is ignored
    @(negedge clk);
    i_TX_Done = 1'b1;
    @(negedge clk);
    i_TX_Done = 1'b0;
    @(negedge clk);
    check("done_in_idle_busy", o_Busy, 0);
    check("done_in_idle_dv", o_TX_DV, 0);

    // Single request from requester 2
    m_byte[2] = 8'hAA;
    kick(4'b0100);
    do_frame(0, 1'b0, 20, '0, gg);
    check("single_grant", gg, 4'b0100);

    // Fairness: all valid, two full rounds in order 0..3
    do_reset();
    m_byte[0] = 8'h10; m_byte[1] = 8'h21; m_byte[2] = 8'h32; m_byte[3] = 8'h43;
    kick(4'b1111);
    for (int k = 0; k < 2 * NUM_REQ; k++) begin
      do_frame(1, 1'b0, 5 + k, '0, gg);
      check("rr_order", gg, 32'(1) << (k % NUM_REQ));
    end

    // Pointer at 2 with only 0 and 3 valid: 3 first, then 0
    do_reset();
    m_byte[1] = 8'h5A;
    kick(4'b0010);
    m_byte[0] = 8'hC0; m_byte[3] = 8'h3C;
    do_frame(0, 1'b0, 8, 4'b1001, gg);
    check("ptr_first", gg, 4'b0010);
    do_frame(0, 1'b0, 8, '0, gg);
    check("ptr_wrap_3", gg, 4'b1000);
    do_frame(0, 1'b0, 8, '0, gg);
    check("ptr_wrap_0", gg, 4'b0001);

    // Watchdog: Done never arrives, then the pending request is served.
    // That next frame lands Done on the timeout edge, where Done must win.
    m_byte[2] = 8'h77;
    kick(4'b0001);
    do_frame(0, 1'b1, 0, 4'b0100, gg);
    check("tmo_owner", gg, 4'b0001);
    do_frame(0, 1'b0, TIMEOUT_CLKS - 1, '0, gg);
    check("tmo_next_grant", gg, 4'b0100);

    // Asynchronous reset mid-frame; the late Done must be ignored
    m_byte[2] = 8'h5C;
    kick(4'b0100);
    i_TX_Active = 1'b1;
    @(negedge clk);
    check("pre_rst_dv", o_TX_DV, 1);
    @(negedge clk);
    @(negedge clk);
    #2 i_Rst_L = 1'b0;
    #1 check("rst_async", {o_Req_Ack, o_Grant, o_TX_DV, o_TX_Byte, o_Busy, o_Err}, 0);
    i_Req_Valid = '0;
    @(negedge clk);
    i_Rst_L = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    i_TX_Done = 1'b1;
    @(negedge clk);
    i_TX_Done = 1'b0;
    i_TX_Active = 1'b0;
    check("stale_done_busy", o_Busy, 0);
    check("stale_done_dv", o_TX_DV, 0);
    m_byte[1] = 8'h11; m_byte[3] = 8'h33;
    kick(4'b1010);
    do_frame(0, 1'b0, 10, '0, gg);
    check("ptr_after_reset", gg, 4'b0010);
    do_frame(0, 1'b0, 10, '0, gg);
    check("second_after_reset", gg, 4'b1000);

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      if (i_Req_Valid == '0) begin
        for (int r = 0; r < NUM_REQ; r++) m_byte[r] = 8'($urandom);
        kick(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)));
      end
      do_frame(2, $urandom_range(0, 24) == 0, $urandom_range(1, 40), '0, gg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
